// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the RV32I multicycle control path: bus width, immediate
// formats, controller states, opcodes and datapath select encodings.
package multicycle_ctrl_pkg;

  localparam int DATA_BUS = 32;

  // Immediate generator format select; I is the idle/reset value.
  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_B  = 3'd2,
    FMT_UI = 3'd3,
    FMT_J  = 3'd4
  } instr_format;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR, ST_MEM_RD,
    ST_MEM_WR, ST_WB, ST_BRANCH, ST_JAL, ST_JALR, ST_UPPER, ST_HALT
  } ctrl_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2} alu_op_t;
  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2} pc_src_t;
  typedef enum logic [1:0] {RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2} result_src_t;

  localparam logic [1:0] SRC_A_RS1  = 2'd0;
  localparam logic [1:0] SRC_A_PC   = 2'd1;
  localparam logic [1:0] SRC_A_ZERO = 2'd2;

  // Immediate format implied by an opcode; unknown opcodes fall back to I.
  function automatic instr_format imm_fmt(input logic [6:0] op);
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: imm_fmt = FMT_I;
      OP_STORE:                 imm_fmt = FMT_S;
      OP_BRANCH:                imm_fmt = FMT_B;
      OP_JAL:                   imm_fmt = FMT_J;
      OP_LUI, OP_AUIPC:         imm_fmt = FMT_UI;
      default:                  imm_fmt = FMT_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// Memory wait watchdog: counts consecutive cycles a request is pending without
// mem_ready and flags a timeout on the last allowed waiting cycle.
// MEM_TIMEOUT = 0 removes the counter and never times out.
module multicycle_ctrl_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req_i,
  input  logic mem_ready_i,
  output logic timeout_o
);

  if (MEM_TIMEOUT == 0) begin : g_off
    logic unused_wd;
    assign unused_wd = ^{clk, rst, mem_req_i, mem_ready_i};
    assign timeout_o = 1'b0;
  end else begin : g_on
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          waiting, last;

    assign waiting   = mem_req_i && !mem_ready_i;
    assign last      = (cnt_q == CW'(MEM_TIMEOUT - 1));
    // mem_ready on the final counted cycle suppresses the timeout.
    assign timeout_o = waiting && last;

    // Count waiting cycles; clear on completion, idle or timeout.
    always_comb begin
      cnt_d = '0;
      if (waiting && !last) cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback for one
// instruction at a time. Optional performance counters are built when
// MULTICYCLE_CTRL_PERF_EN is defined (adds cycle_cnt / instret_cnt).
// Handshake: a memory request holds mem_req (and mem_we) high every cycle
// until the cycle mem_ready is sampled high; that cycle completes it.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
`ifdef MULTICYCLE_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_BUS-1:0] instr,
  input  logic                alu_zero,
  input  logic                alu_lt,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output pc_src_t             pc_src,
  output instr_format         imm_src,
  output logic [1:0]          alu_src_a,
  output logic                alu_src_b,
  output alu_op_t             alu_op,
  output logic                cmp_unsigned,
  output logic                reg_write,
  output result_src_t         result_src,
`ifdef MULTICYCLE_CTRL_PERF_EN
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instret_cnt,
`endif
  output ctrl_state_t         dbg_state_o,
  output logic                trap
);

  ctrl_state_t state_q, state_d;
  instr_format imm_q, imm_d;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        wd_active, wd_timeout;
  logic        taken, bad_branch;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[DATA_BUS-1:15], instr[11:7]};
  assign dbg_state_o  = state_q;

  // The watchdog only sees the states that issue memory requests.
  assign wd_active = !rst && (state_q == ST_FETCH || state_q == ST_MEM_RD ||
                              state_q == ST_MEM_WR);

  multicycle_ctrl_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
    .clk         (clk),
    .rst         (rst),
    .mem_req_i   (wd_active),
    .mem_ready_i (mem_ready),
    .timeout_o   (wd_timeout)
  );

  // State and latched immediate format registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      imm_q   <= FMT_I;
    end else begin
      state_q <= state_d;
      imm_q   <= imm_d;
    end
  end

  // Next-state and Moore control decode; reset forces every control low.
  always_comb begin
    state_d      = state_q;
    imm_d        = imm_q;
    imm_src      = imm_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src_a    = SRC_A_RS1;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    cmp_unsigned = 1'b0;
    reg_write    = 1'b0;
    result_src   = RES_ALU;
    trap         = 1'b0;
    taken        = 1'b0;
    bad_branch   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end else if (wd_timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        imm_src = imm_fmt(opcode);
        imm_d   = imm_fmt(opcode);
        case (opcode)
          OP_R:               state_d = ST_EXEC_R;
          OP_IMM:             state_d = ST_EXEC_I;
          OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
          OP_BRANCH:          state_d = ST_BRANCH;
          OP_JAL:             state_d = ST_JAL;
          OP_JALR:            state_d = ST_JALR;
          OP_LUI, OP_AUIPC:   state_d = ST_UPPER;
          default:            state_d = ST_HALT;
        endcase
      end
      ST_EXEC_R: begin
        alu_op    = ALU_FUNCT;
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_op    = ALU_FUNCT;
        alu_src_b = 1'b1;
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_b = 1'b1;
        state_d   = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready)       state_d = ST_WB;
        else if (wd_timeout) state_d = ST_HALT;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready)       state_d = ST_FETCH;
        else if (wd_timeout) state_d = ST_HALT;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_op       = ALU_SUB;
        cmp_unsigned = (funct3[2:1] == 2'b11);
        case (funct3)
          3'b000:  taken = alu_zero;
          3'b001:  taken = !alu_zero;
          3'b100:  taken = alu_lt;
          3'b101:  taken = !alu_lt;
          3'b110:  taken = alu_lt;
          3'b111:  taken = !alu_lt;
          default: bad_branch = 1'b1;
        endcase
        if (bad_branch) begin
          state_d = ST_HALT;
        end else begin
          pc_write = taken;
          pc_src   = taken ? PC_IMM : PC_PLUS4;
          state_d  = ST_FETCH;
        end
      end
      ST_JAL: begin
        reg_write  = 1'b1;
        result_src = RES_PC4;
        pc_write   = 1'b1;
        pc_src     = PC_IMM;
        state_d    = ST_FETCH;
      end
      ST_JALR: begin
        alu_src_b  = 1'b1;
        reg_write  = 1'b1;
        result_src = RES_PC4;
        pc_write   = 1'b1;
        pc_src     = PC_ALU;
        state_d    = ST_FETCH;
      end
      ST_UPPER: begin
        alu_src_b = 1'b1;
        alu_src_a = (opcode == OP_LUI) ? SRC_A_ZERO : SRC_A_PC;
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        trap = 1'b1;
      end
      default: state_d = ST_HALT;
    endcase

    // An instruction caught by reset is abandoned without any side effect.
    if (rst) begin
      imm_src      = FMT_I;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_PLUS4;
      alu_src_a    = SRC_A_RS1;
      alu_src_b    = 1'b0;
      alu_op       = ALU_ADD;
      cmp_unsigned = 1'b0;
      reg_write    = 1'b0;
      result_src   = RES_ALU;
      trap         = 1'b0;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  // Free-running cycle count outside HALT; retire count on each return to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != ST_HALT) cycle_q <= cycle_q + 1'b1;
      if (state_q != ST_FETCH && state_d == ST_FETCH) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I core.
- Sequences fetch/decode/execute/memory/writeback for one instruction at a time.
- Drives the immediate-format select into the immediate generator, plus ALU, register-file, PC and memory-handshake controls.
- Sits between the instruction register and the shared datapath.

Parameters:
- MEM_TIMEOUT, 16, max cycles mem_req may wait for mem_ready before trap; 0 disables the watchdog.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- instr  in  DATA_BUS  instruction register contents; valid from DECODE onward.
- alu_zero  in  1  ALU result == 0.
- alu_lt  in  1  ALU less-than, signed or unsigned per cmp_unsigned.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- mem_we  out  1  request is a write.
- ir_write  out  1  load instr register.
- pc_write  out  1  update PC.
- pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALU result with bit0 cleared.
- imm_src  out  instr_format  I/S/UI/B/J select for the immediate generator.
- alu_src_a  out  2  0=rs1, 1=PC, 2=zero.
- alu_src_b  out  1  0=rs2, 1=ImmOp.
- alu_op  out  2  0=ADD, 1=SUB, 2=use funct3/funct7.
- cmp_unsigned  out  1  unsigned compare (BLTU/BGEU).
- reg_write  out  1  register-file write.
- result_src  out  2  0=ALU, 1=mem data, 2=PC+4.
- trap  out  1  sticky illegal-instruction or timeout flag.

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB, BRANCH, JAL, JALR, UPPER, HALT.
- Outputs are Moore, decoded from the state register and instr.
- Reset: state=FETCH. All control outputs 0, imm_src=I, trap=0, watchdog=0. Reset mid-operation aborts the instruction with no write.
- FETCH: mem_req=1, mem_we=0, held until mem_ready. In the mem_ready cycle: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: one cycle. imm_src is set from opcode and held stable until the next FETCH:
  - 0010011/0000011/1100111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 1101111 -> J
  - 0110111/0010111 -> UI
- DECODE next state:
  - R-type 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - load/store -> MEM_ADDR
  - branch -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI/AUIPC -> UPPER
  - any other opcode -> HALT
- EXEC_R: alu_op=2, src_b=0, reg_write=1, result_src=0 -> FETCH.
- EXEC_I: alu_op=2, src_b=1, reg_write=1 -> FETCH.
- MEM_ADDR: alu_op=0, src_b=1, one cycle -> MEM_RD if load, MEM_WR if store.
- MEM_RD: mem_req=1 until mem_ready -> WB.
- MEM_WR: mem_req=1, mem_we=1 until mem_ready -> FETCH.
- WB: reg_write=1, result_src=1 -> FETCH.
- BRANCH: alu_op=1, src_b=0. Taken conditions:
  - funct3 000: alu_zero
  - 001: !alu_zero
  - 100: alu_lt
  - 101: !alu_lt
  - 110: alu_lt with cmp_unsigned=1
  - 111: !alu_lt with cmp_unsigned=1
  - 010/011 -> HALT
- BRANCH taken: pc_write=1, pc_src=1. Not taken: no PC write. Either way -> FETCH.
- JAL: reg_write=1, result_src=2, pc_write=1, pc_src=1 -> FETCH.
- JALR: alu_src_a=0, src_b=1, alu_op=0, reg_write=1, result_src=2, pc_write=1, pc_src=2 -> FETCH.
- UPPER: src_b=1, alu_op=0, src_a=2 (LUI) or 1 (AUIPC), reg_write=1 -> FETCH.
- Latency: R/I/upper/jump 3 cycles; branch 3; store 4; load 5. Each excludes memory wait cycles.
- Watchdog:
  - Counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or on leaving a memory state.
  - On count==MEM_TIMEOUT-1 with mem_ready still 0 -> HALT.
  - mem_ready in the same cycle as the final count wins; no trap.
- HALT: trap=1, every enable 0, mem_req=0. Left only by rst.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined: adds outputs cycle_cnt and instret_cnt (CNT_W each).
  - cycle_cnt increments every non-reset cycle outside HALT.
  - instret_cnt increments on each transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^CNT_W and reset to 0.
- When undefined: the ports are absent and no counter logic exists.

Decomposition:
- Add to types_pkg:
  - ctrl_state_t enum.
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC).
  - alu_op_t, pc_src_t, result_src_t enums.
- Reuse existing DATA_BUS and instr_format.
- Sub-module mem_watchdog: counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
- ADDI 0x00500093, mem_ready immediate -> FETCH,DECODE,EXEC_I; imm_src=I; reg_write=1 only in cycle 3; back in FETCH cycle 4.
- SW 0x00112223 with mem_ready delayed 3 cycles -> imm_src=S; mem_we=1 for 4 cycles; no reg_write; trap=0.
- BNE 0x00209463: alu_zero=0 -> pc_write=1, pc_src=1. Repeat with alu_zero=1 -> no pc_write; imm_src=B.
- LUI 0x123450B7 -> imm_src=UI, alu_src_a=2, reg_write=1. JAL 0x008000EF -> imm_src=J, result_src=2, pc_src=1.
- Opcode 0x0000007F -> HALT, trap=1 persists 10 cycles. rst for 1 cycle -> FETCH, trap=0.
- MEM_TIMEOUT=4, mem_ready held 0 in MEM_RD -> HALT after 4 waiting cycles. mem_ready on the 4th waiting cycle -> WB, no trap.
